ring_freq_meter: RTL and testbench
==================================

RING_FREQ_METER -- requirements
Module: ring_freq_meter

Interface
REQ-001 SHALL provide parameter pGATE, default 1024: gate window length in i_clk cycles, range 4..65535.
REQ-002 SHALL provide parameter pWIDTH, default 16: edge-count width in bits, range 8..24.
REQ-003 SHALL provide port i_clk, input, 1: the single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port i_rst, input, 1: synchronous active-high reset, sampled on the rising edge of i_clk.
REQ-005 SHALL provide port i_ring, input, 6: free-running ring-oscillator clocks (5, 11, 23, 47, 97, 197 stages on bits 0..5), asynchronous to i_clk.
REQ-006 SHALL provide port i_sel, input, 3: ring select; values 6 and 7 select a constant 0.
REQ-007 SHALL provide port i_start, input, 1: measurement request, level-sampled.
REQ-008 SHALL provide port o_busy, output, 1: high while a measurement is in progress.
REQ-009 SHALL provide port o_valid, output, 1: one-cycle pulse marking a new o_count.
REQ-010 SHALL provide port o_count, output, pWIDTH: rising edges of the selected ring counted in the last gate window.

Function
REQ-011 SHALL pass the selected ring bit through a 2-flop synchronizer, then a history flop for edge detection; a rising edge is sync=1 and history=0.
REQ-012 SHALL clock the synchronizer and history flops every i_clk cycle in all states, so no false edge appears at gate open.
REQ-013 SHALL implement FSM states IDLE, SETTLE, GATE and DONE.
REQ-014 IDLE: if i_start=1, latch i_sel into the internal select register, clear the edge counter and go to SETTLE; otherwise stay in IDLE.
REQ-015 SETTLE SHALL last exactly 3 cycles to flush the synchronizer after the select change, then go to GATE.
REQ-016 GATE SHALL last exactly pGATE cycles and count every detected rising edge in those cycles, then go to DONE.
REQ-017 DONE SHALL last 1 cycle: o_count takes the counter value, o_valid=1, then go to IDLE.
REQ-018 If i_start is sampled at edge N in IDLE: o_busy=1 in cycles N+1 .. N+3+pGATE; o_valid=1 and o_busy=0 in cycle N+4+pGATE only.
REQ-019 SHALL ignore i_start in SETTLE, GATE and DONE, with no queuing; held-high i_start gives back-to-back measurements with one IDLE cycle between them.
REQ-020 SHALL ignore changes to i_sel after the start cycle until the next accepted start.
REQ-021 The edge counter SHALL saturate at 2^pWIDTH-1 and never wrap.
REQ-022 o_count SHALL hold its value between DONE cycles.
REQ-023 Measured accuracy is guaranteed only for ring frequencies below f(i_clk)/2; faster rings alias, and that is a legal result, not an error.
REQ-024 SHALL use the gate-cycle counter width ceil(log2(pGATE+1)).
REQ-025 SHALL have no combinational path from any input to any output.

Reset
REQ-026 i_rst=1 at any edge SHALL force the FSM to IDLE, clear the edge and gate counters, the select register, and all synchronizer and history flops, and set o_busy=0, o_valid=0, o_count=0.
REQ-027 Reset mid-measurement SHALL abort it with no o_valid pulse; the first i_start after i_rst deasserts SHALL be accepted normally.
REQ-028 i_rst SHALL take priority over i_start in the same cycle.

Verification (pGATE=16, pWIDTH=8 unless stated; ring stimulus toggled synchronously to i_clk)
REQ-029 i_ring[0] toggling every 2 cycles (period 4), i_sel=0, i_start pulsed 1 cycle -> o_valid exactly 20 cycles after the start edge, o_count=4, o_busy high for 19 cycles.
REQ-030 i_sel=6 with all rings toggling -> o_count=0; separately, i_ring[2] at period 2 with i_sel=2 -> o_count=8.
REQ-031 pWIDTH=8, pGATE=1024, selected ring at period 2 -> o_count=255 (saturated), no wrap.
REQ-032 i_rst=1 asserted 5 cycles into GATE -> o_busy=0 the next cycle, no o_valid, o_count=0; a new start then yields a correct count.
REQ-033 i_start held high continuously -> o_valid pulses every 21 cycles; i_sel changed during GATE -> the result reflects the latched select.
REQ-034 i_start asserted during SETTLE/GATE/DONE -> ignored, single o_valid.

Source files
------------

// File: rtl/ring_freq_meter.sv
// ring_freq_meter
//   Measures the frequency of one of six free-running ring oscillators by
//   counting its rising edges during a fixed window of pGATE system-clock
//   cycles.  The selected ring is resynchronised into the i_clk domain, so
//   rings faster than f(i_clk)/2 alias.  An alias is still a valid result.
//
// Ports
//   i_clk    system clock; all state changes on its rising edge
//   i_rst    synchronous active-high reset
//   i_ring   six asynchronous ring-oscillator outputs (bits 0..5)
//   i_sel    ring select; 6 and 7 select a constant 0
//   i_start  measurement request, level-sampled while idle
//   o_busy   high while a measurement is in progress (SETTLE and GATE)
//   o_valid  one-cycle pulse that marks a new o_count
//   o_count  rising edges counted in the last gate window, saturating
module ring_freq_meter #(
    parameter int pGATE  = 1024,
    parameter int pWIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [5:0]        i_ring,
    input  logic [2:0]        i_sel,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_valid,
    output logic [pWIDTH-1:0] o_count
);

    localparam int GW = $clog2(pGATE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic                sync1_q, sync2_q, hist_q;
    logic [pWIDTH-1:0]   edge_cnt_q, edge_cnt_d;
    logic [GW-1:0]       gate_cnt_q, gate_cnt_d;
    logic [pWIDTH-1:0]   count_q, count_d;
    logic                ring_sel;
    logic                edge_det;

    // The increment stops at all-ones so that a fast ring reads full scale.
    // Letting it wrap would read low.
    function automatic logic [pWIDTH-1:0] sat_inc(input logic [pWIDTH-1:0] v,
                                                  input logic inc);
        if (inc && (v != {pWIDTH{1'b1}})) begin
            return v + {{(pWIDTH-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

    // Select mux feeds the synchroniser.  The mux is driven by the latched
    // select, so changes to i_sel mid-measurement have no effect.
    always_comb begin
        ring_sel = 1'b0;
        case (sel_q)
            3'd0:    ring_sel = i_ring[0];
            3'd1:    ring_sel = i_ring[1];
            3'd2:    ring_sel = i_ring[2];
            3'd3:    ring_sel = i_ring[3];
            3'd4:    ring_sel = i_ring[4];
            3'd5:    ring_sel = i_ring[5];
            default: ring_sel = 1'b0;
        endcase
    end

    assign edge_det = sync2_q & ~hist_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        edge_cnt_d = edge_cnt_q;
        gate_cnt_d = gate_cnt_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sel_d      = i_sel;
                    edge_cnt_d = '0;
                    gate_cnt_d = '0;
                    state_d    = SETTLE;
                end
            end
            // Three cycles flush the old ring out of sync1/sync2/history.
            // The gate counter is reused for this; pGATE >= 4 guarantees
            // it is wide enough to count to 2.
            SETTLE: begin
                if (gate_cnt_q == GW'(2)) begin
                    gate_cnt_d = '0;
                    state_d    = GATE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                end
            end
            GATE: begin
                edge_cnt_d = sat_inc(edge_cnt_q, edge_det);
                if (gate_cnt_q == GW'(pGATE - 1)) begin
                    // The result is loaded on entry to DONE.  The edge seen
                    // in the last gate cycle is included, and o_count is
                    // stable for the whole o_valid cycle.
                    count_d    = edge_cnt_d;
                    gate_cnt_d = '0;
                    state_d    = DONE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            edge_cnt_q <= '0;
            gate_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            // The synchroniser runs in every state, so it already holds
            // settled data when the gate opens.
            sync1_q    <= ring_sel;
            sync2_q    <= sync1_q;
            hist_q     <= sync2_q;
            edge_cnt_q <= edge_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            count_q    <= count_d;
        end
    end

    // All outputs decode registered state only.
    assign o_busy  = (state_q == SETTLE) || (state_q == GATE);
    assign o_valid = (state_q == DONE);
    assign o_count = count_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter
//   Directed bench for ring_freq_meter.  One instance uses pGATE=16 and
//   pWIDTH=8.  A second instance uses pGATE=1024 and pWIDTH=8 and is used
//   for the saturation case.  Ring bits are toggled synchronously to the
//   clock with a per-bit half-period.
module tb_ring_freq_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] ring = '0;
    logic [2:0] sel = '0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;

    logic       busy, valid;
    logic [7:0] count;
    logic       sat_busy, sat_valid;
    logic [7:0] sat_count;

    int errors = 0;
    int checks = 0;
    int half[6] = '{0, 0, 0, 0, 0, 0};
    int hcnt[6] = '{0, 0, 0, 0, 0, 0};

    ring_freq_meter #(.pGATE(16), .pWIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_ring(ring), .i_sel(sel),
        .i_start(start), .o_busy(busy), .o_valid(valid), .o_count(count)
    );

    ring_freq_meter #(.pGATE(1024), .pWIDTH(8)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_ring(ring), .i_sel(sel),
        .i_start(start2), .o_busy(sat_busy), .o_valid(sat_valid),
        .o_count(sat_count)
    );

    always #5 clk = ~clk;

    // Ring generator: a bit with half[b]=h toggles every h clock cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int b = 0; b < 6; b++) begin
                if (half[b] > 0) begin
                    hcnt[b] = hcnt[b] + 1;
                    if (hcnt[b] >= half[b]) begin
                        ring[b] = ~ring[b];
                        hcnt[b] = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rings(input int h0, input int h1, input int h2,
                             input int h3, input int h4, input int h5);
        half[0] = h0; half[1] = h1; half[2] = h2;
        half[3] = h3; half[4] = h4; half[5] = h5;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        start = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int c;
        int busy_n;
        set_rings(2, 0, 0, 0, 0, 0);
        sel = 3'd0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        busy_n = 0;
        while (valid !== 1'b1 && c < 60) begin
            if (busy === 1'b1) busy_n++;
            tick();
            c++;
        end
        checks++;
        if (c !== 20) begin errors++; $display("FAIL basic_latency got=%0d exp=20", c); end
        checks++;
        if (busy_n !== 19) begin errors++; $display("FAIL basic_busy_len got=%0d exp=19", busy_n); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_valid got=%b exp=0", busy); end
        checks++;
        if (count !== 8'd4) begin errors++; $display("FAIL basic_count got=%0d exp=4", count); end
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got=%b exp=0", valid); end
        repeat (5) tick();
        checks++;
        if (count !== 8'd4) begin errors++; $display("FAIL basic_count_hold got=%0d exp=4", count); end
    endtask

    task automatic test_select();
        int c;
        // Select 6 with every ring toggling yields zero.
        set_rings(1, 1, 1, 1, 1, 1);
        sel = 3'd6;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (valid !== 1'b1 && c < 60) begin tick(); c++; end
        checks++;
        if (valid !== 1'b1 || count !== 8'd0) begin
            errors++; $display("FAIL sel6_count got=%0d valid=%b exp=0", count, valid);
        end
        // Ring 2 at period 2 while the others are static yields 8.
        tick();
        set_rings(0, 0, 1, 0, 0, 0);
        sel = 3'd2;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (valid !== 1'b1 && c < 60) begin tick(); c++; end
        checks++;
        if (valid !== 1'b1 || count !== 8'd8) begin
            errors++; $display("FAIL sel2_count got=%0d valid=%b exp=8", count, valid);
        end
        tick();
    endtask

    task automatic test_saturate();
        int c;
        set_rings(1, 0, 0, 0, 0, 0);
        sel = 3'd0;
        repeat (3) tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        c = 1;
        while (sat_valid !== 1'b1 && c < 1200) begin tick(); c++; end
        checks++;
        if (c !== 1028) begin errors++; $display("FAIL sat_latency got=%0d exp=1028", c); end
        checks++;
        if (sat_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", sat_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        int vcount;
        set_rings(2, 0, 0, 0, 0, 0);
        sel = 3'd0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        // GATE begins at c=4; the reset edge is the fifth gate edge.
        for (c = 1; c < 8; c++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++;
        if (count !== 8'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid === 1'b1) vcount++;
            tick();
        end
        checks++;
        if (vcount !== 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", vcount); end
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (valid !== 1'b1 && c < 60) begin tick(); c++; end
        checks++;
        if (c !== 20 || count !== 8'd4) begin
            errors++; $display("FAIL rstmid_restart got count=%0d at %0d exp=4 at 20", count, c);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int c;
        int nv;
        int t[3];
        int v[3];
        set_rings(2, 0, 0, 0, 0, 0);
        sel = 3'd0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        c = 1;
        nv = 0;
        while (nv < 3 && c < 100) begin
            if (valid === 1'b1) begin
                t[nv] = c;
                v[nv] = int'(count);
                nv++;
                if (nv == 3) start = 1'b0;
            end
            // Select changes inside both gate windows; the latched select rules.
            if (c == 8 || c == 30) sel = 3'd6;
            if (c == 15 || c == 36) sel = 3'd0;
            if (nv < 3) begin tick(); c++; end
        end
        start = 1'b0;
        checks++;
        if (nv !== 3) begin
            errors++; $display("FAIL b2b_pulses got=%0d exp=3", nv);
        end else begin
            checks++;
            if (t[0] !== 20 || t[1] !== 41 || t[2] !== 62) begin
                errors++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=20,41,62", t[0], t[1], t[2]);
            end
            checks++;
            if (v[0] !== 4 || v[1] !== 4 || v[2] !== 4) begin
                errors++; $display("FAIL b2b_latched_sel got=%0d,%0d,%0d exp=4,4,4", v[0], v[1], v[2]);
            end
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy=%b exp=0", busy); end
    endtask

    task automatic test_ignore_start();
        int vcount;
        set_rings(2, 0, 0, 0, 0, 0);
        sel = 3'd0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vcount = 0;
        // Start is pulsed while the meter is in SETTLE (c=2), GATE (c=10)
        // and DONE (c=20).
        for (int c = 1; c < 60; c++) begin
            if (valid === 1'b1) begin
                vcount++;
                checks++;
                if (count !== 8'd4) begin errors++; $display("FAIL ignore_count got=%0d exp=4", count); end
            end
            start = (c == 2 || c == 10 || c == 20);
            tick();
        end
        start = 1'b0;
        checks++;
        if (vcount !== 1) begin errors++; $display("FAIL ignore_single_valid got=%0d exp=1", vcount); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_select();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        test_ignore_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
